// File: rtl/timing_loop_ctrl_pkg.sv
// Shared types for the symbol-timing loop controller: loop state encoding,
// loop-filter gain payload and gain helpers.
package timing_ctrl_pkg;

  localparam int unsigned SHIFT_W = 5;

  localparam int unsigned DEF_ACQ_KP_SHIFT = 5;
  localparam int unsigned DEF_ACQ_KI_SHIFT = 9;
  localparam int unsigned DEF_TRK_KP_SHIFT = 7;
  localparam int unsigned DEF_TRK_KI_SHIFT = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACQ    = 2'd2,
    ST_TRACK  = 2'd3
  } tloop_state_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] kp;
    logic [SHIFT_W-1:0] ki;
  } gain_t;

  function automatic gain_t make_gain(input int unsigned kp, input int unsigned ki);
    gain_t g;
    g.kp = SHIFT_W'(kp);
    g.ki = SHIFT_W'(ki);
    return g;
  endfunction

  // Only TRACK runs the narrow loop; every other state uses acquisition gains.
  function automatic gain_t gain_for(input tloop_state_t st, input gain_t acq, input gain_t trk);
    return (st == ST_TRACK) ? trk : acq;
  endfunction

endpackage

// File: rtl/timing_loop_ctrl_if.sv
// Control/status bundle between the timing-loop controller and the TED /
// loop filter / phase accumulator datapath.
interface timing_loop_ctrl_if
  import timing_ctrl_pkg::*;
#(
  parameter int unsigned WERR     = 18,
  parameter int unsigned WIN_LOG2 = 8
) ();

  logic                      enable_i;
  logic signed [WERR-1:0]    e_in_i;
  logic                      e_valid_i;
  logic                      sym_valid_i;
  logic [SHIFT_W-1:0]        kp_shift_o;
  logic [SHIFT_W-1:0]        ki_shift_o;
  logic                      lf_clear_o;
  logic                      freeze_o;
  logic                      locked_o;
  logic [1:0]                state_o;
  logic [WERR+WIN_LOG2-1:0]  win_sum_o;

  modport master (
    output enable_i, e_in_i, e_valid_i, sym_valid_i,
    input  kp_shift_o, ki_shift_o, lf_clear_o, freeze_o, locked_o, state_o, win_sum_o
  );

  modport slave (
    input  enable_i, e_in_i, e_valid_i, sym_valid_i,
    output kp_shift_o, ki_shift_o, lf_clear_o, freeze_o, locked_o, state_o, win_sum_o
  );

endinterface

// File: rtl/timing_loop_ctrl_err_window_accum.sv
// Windowed sum of |e| over 2**WIN_LOG2 valid TED errors; flags the sample that
// completes a window and latches the finished sum.
module err_window_accum #(
  parameter int unsigned WERR     = 18,
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          active,
  input  logic                          clear,
  input  logic                          e_valid,
  input  logic signed [WERR-1:0]        e_in,
  output logic                          done_c,
  output logic [WERR-1+WIN_LOG2-1:0]    sum_c,
  output logic [WERR-1+WIN_LOG2-1:0]    win_sum
);

  localparam int unsigned MAG_W = WERR - 1;
  localparam int unsigned SUM_W = MAG_W + WIN_LOG2;

  logic [WERR-1:0]     neg_c;
  logic [MAG_W-1:0]    mag_c;
  logic                take_c;
  logic [SUM_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] cnt_q;

  // Magnitude with the most negative code saturated to the largest positive.
  always_comb begin
    neg_c = -e_in;
    mag_c = e_in[MAG_W-1:0];
    if (e_in[WERR-1]) begin
      if (e_in[MAG_W-1:0] == '0) mag_c = '1;
      else                       mag_c = neg_c[MAG_W-1:0];
    end
    take_c = active & e_valid;
    done_c = take_c & (cnt_q == '1);
    sum_c  = acc_q + SUM_W'(mag_c);
  end

  // A completing sample still publishes its window even when the caller clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      win_sum <= '0;
    end else begin
      if (done_c) win_sum <= sum_c;
      if (clear || done_c) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (take_c) begin
        acc_q <= sum_c;
        cnt_q <= cnt_q + WIN_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/timing_loop_ctrl.sv
// Symbol-timing loop sequencer: gain scheduling, loop-filter hold/clear and
// lock detection from windowed mean |e|.
module timing_loop_ctrl
  import timing_ctrl_pkg::*;
#(
  parameter int unsigned WERR         = 18,
  parameter int unsigned WIN_LOG2     = 8,
  parameter int unsigned SETTLE_SYMS  = 64,
  parameter int unsigned ACQ_KP_SHIFT = DEF_ACQ_KP_SHIFT,
  parameter int unsigned ACQ_KI_SHIFT = DEF_ACQ_KI_SHIFT,
  parameter int unsigned TRK_KP_SHIFT = DEF_TRK_KP_SHIFT,
  parameter int unsigned TRK_KI_SHIFT = DEF_TRK_KI_SHIFT,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned UNLOCK_CNT   = 2
) (
  input logic               clk,
  input logic               reset_n,
  timing_loop_ctrl_if.slave bus
);

  localparam int unsigned SUM_W  = WERR - 1 + WIN_LOG2;
  localparam int unsigned SET_W  = $clog2(SETTLE_SYMS + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [SUM_W-1:0] LOCK_THRESH   = SUM_W'(1) << (WERR - 4 + WIN_LOG2);
  localparam logic [SUM_W-1:0] UNLOCK_THRESH = SUM_W'(1) << (WERR - 3 + WIN_LOG2);

  localparam gain_t ACQ_GAIN = make_gain(ACQ_KP_SHIFT, ACQ_KI_SHIFT);
  localparam gain_t TRK_GAIN = make_gain(TRK_KP_SHIFT, TRK_KI_SHIFT);

  tloop_state_t      state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  gain_t             gain_q;
  logic              lf_clear_q, freeze_q, locked_q;
  logic              change_c;
  logic              win_active_c;
  logic              win_done_c;
  logic [SUM_W-1:0]  win_next_c;
  logic [SUM_W-1:0]  win_sum_q;

  assign win_active_c = (state_q == ST_ACQ) || (state_q == ST_TRACK);

  err_window_accum #(
    .WERR     (WERR),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (win_active_c),
    .clear   (change_c),
    .e_valid (bus.e_valid_i),
    .e_in    (bus.e_in_i),
    .done_c  (win_done_c),
    .sum_c   (win_next_c),
    .win_sum (win_sum_q)
  );

  // Next-state and counter updates; dropping enable overrides every other event.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    good_d   = good_q;
    bad_d    = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.sym_valid_i) begin
          if (settle_q == SET_W'(SETTLE_SYMS - 1)) state_d = ST_ACQ;
          else                                     settle_d = settle_q + SET_W'(1);
        end
      end
      ST_ACQ: begin
        if (win_done_c) begin
          if (win_next_c < LOCK_THRESH) begin
            if (good_q == GOOD_W'(LOCK_CNT - 1)) state_d = ST_TRACK;
            else                                 good_d = good_q + GOOD_W'(1);
          end else begin
            good_d = '0;
          end
        end
      end
      ST_TRACK: begin
        if (win_done_c) begin
          if (win_next_c > UNLOCK_THRESH) begin
            if (bad_q == BAD_W'(UNLOCK_CNT - 1)) state_d = ST_ACQ;
            else                                 bad_d = bad_q + BAD_W'(1);
          end else begin
            bad_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!bus.enable_i) state_d = ST_IDLE;
    change_c = (state_d != state_q);
    if (change_c) begin
      settle_d = '0;
      good_d   = '0;
      bad_d    = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      gain_q     <= ACQ_GAIN;
      lf_clear_q <= 1'b0;
      freeze_q   <= 1'b1;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      if (change_c) gain_q <= gain_for(state_d, ACQ_GAIN, TRK_GAIN);
      lf_clear_q <= (state_q == ST_IDLE) && (state_d == ST_SETTLE);
      freeze_q   <= (state_d == ST_IDLE);
      locked_q   <= (state_d == ST_TRACK);
    end
  end

  assign bus.kp_shift_o = gain_q.kp;
  assign bus.ki_shift_o = gain_q.ki;
  assign bus.lf_clear_o = lf_clear_q;
  assign bus.freeze_o   = freeze_q;
  assign bus.locked_o   = locked_q;
  assign bus.state_o    = state_q;
  assign bus.win_sum_o  = {1'b0, win_sum_q};

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Randomized bench for timing_loop_ctrl against a queue-based behavioural model
// of the loop sequencing rules, plus directed scenario checkpoints.
module tb_timing_loop_ctrl;

  localparam longint LOCK_T   = 64'd1 << 22;
  localparam longint UNLOCK_T = 64'd1 << 23;
  localparam int     WIN      = 256;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  timing_loop_ctrl_if #(.WERR(18), .WIN_LOG2(8)) bus ();

  timing_loop_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_state, m_settle, m_good, m_bad, m_kp, m_ki;
  bit          m_clr, m_frz, m_lock;
  longint      m_win_sum;
  int unsigned win_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_settle = 0; m_good = 0; m_bad = 0;
    m_kp = 5; m_ki = 9; m_clr = 0; m_frz = 1; m_lock = 0;
    m_win_sum = 0;
    win_q.delete();
  endfunction

  function automatic void model_step();
    int     e, mag, nxt;
    bit     done;
    longint s;
    if (!reset_n) begin
      model_reset();
      return;
    end
    e    = int'(bus.e_in_i);
    mag  = (e < 0) ? ((e == -131072) ? 131071 : -e) : e;
    done = 0;
    s    = 0;
    if (m_state >= 2 && bus.e_valid_i) begin
      win_q.push_back(mag);
      if (win_q.size() == WIN) begin
        foreach (win_q[i]) s += win_q[i];
        done = 1;
        m_win_sum = s;
        win_q.delete();
      end
    end
    nxt = m_state;
    case (m_state)
      0: if (bus.enable_i) nxt = 1;
      1: if (bus.sym_valid_i) begin m_settle++; if (m_settle == 64) nxt = 2; end
      2: if (done) begin
           if (s < LOCK_T) begin m_good++; if (m_good == 4) nxt = 3; end
           else m_good = 0;
         end
      default: if (done) begin
           if (s > UNLOCK_T) begin m_bad++; if (m_bad == 2) nxt = 2; end
           else m_bad = 0;
         end
    endcase
    if (!bus.enable_i) nxt = 0;
    m_clr = (m_state == 0) && (nxt == 1);
    if (nxt != m_state) begin
      m_settle = 0; m_good = 0; m_bad = 0;
      win_q.delete();
      m_kp = (nxt == 3) ? 7 : 5;
      m_ki = (nxt == 3) ? 12 : 9;
    end
    m_state = nxt;
    m_frz   = (nxt == 0);
    m_lock  = (nxt == 3);
  endfunction

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("state",    bus.state_o,    m_state);
    check("kp",       bus.kp_shift_o, m_kp);
    check("ki",       bus.ki_shift_o, m_ki);
    check("lf_clear", bus.lf_clear_o, m_clr);
    check("freeze",   bus.freeze_o,   m_frz);
    check("locked",   bus.locked_o,   m_lock);
    check("win_sum",  bus.win_sum_o,  m_win_sum);
  endtask

  task automatic drive(input bit en, input bit ev, input int e, input bit sv);
    bus.enable_i    = en;
    bus.e_valid_i   = ev;
    bus.e_in_i      = 18'(e);
    bus.sym_valid_i = sv;
  endtask

  function automatic int pick_err(input int mode);
    int mag;
    case (mode)
      0:       mag = int'($urandom_range(0, 100));
      1:       mag = int'($urandom_range(35000, 60000));
      2:       mag = 16384;
      3:       mag = 32768;
      default: return -131072;
    endcase
    return ($urandom_range(0, 1) != 0) ? -mag : mag;
  endfunction

  // Feeds one full window of valid errors with random idle gaps.
  task automatic run_window(input int mode, input bit drop_last);
    for (int k = 0; k < WIN; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        drive(1'b1, 1'b0, int'($urandom_range(0, 200000)) - 100000, 1'($urandom_range(0, 1)));
        cyc();
      end
      drive((k == WIN - 1) ? !drop_last : 1'b1, 1'b1, pick_err(mode), 1'($urandom_range(0, 1)));
      cyc();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b0);

    // Reset held 4 clocks with enable high
    for (int i = 0; i < 4; i++) cyc();
    check("rst_state", bus.state_o, 0);
    check("rst_freeze", bus.freeze_o, 1);
    check("rst_kp", bus.kp_shift_o, 5);
    check("rst_ki", bus.ki_shift_o, 9);
    check("rst_locked", bus.locked_o, 0);

    // Idle a while, then start and run SETTLE to ACQ
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 1234, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    drive(1'b1, 1'b0, 0, 1'b0);
    cyc();
    check("start_state", bus.state_o, 1);
    check("start_clear", bus.lf_clear_o, 1);
    for (int i = 0; i < 1000 && m_state != 2; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 200)) - 100,
            1'($urandom_range(0, 1)));
      cyc();
    end
    check("settle_done", bus.state_o, 2);

    // Acquire with small errors
    for (int w = 0; w < 4; w++) run_window(0, 1'b0);
    check("acq_state", bus.state_o, 3);
    check("acq_kp", bus.kp_shift_o, 7);
    check("acq_ki", bus.ki_shift_o, 12);
    check("acq_locked", bus.locked_o, 1);

    // Unlock with large errors
    for (int w = 0; w < 2; w++) run_window(1, 1'b0);
    check("unlk_state", bus.state_o, 2);
    check("unlk_locked", bus.locked_o, 0);

    // Hysteresis: alternating windows never lock
    for (int w = 0; w < 10; w++) begin
      run_window(0, 1'b0);
      run_window(1, 1'b0);
    end
    check("hyst_state", bus.state_o, 2);

    // Sum equal to lock threshold breaks the good run
    for (int w = 0; w < 3; w++) run_window(0, 1'b0);
    run_window(2, 1'b0);
    check("eq_lock_sum", bus.win_sum_o, LOCK_T);
    for (int w = 0; w < 3; w++) run_window(0, 1'b0);
    check("eq_lock_state", bus.state_o, 2);
    run_window(0, 1'b0);
    check("relock_state", bus.state_o, 3);

    // Sum equal to unlock threshold breaks the bad run
    run_window(1, 1'b0);
    run_window(3, 1'b0);
    check("eq_unlk_sum", bus.win_sum_o, UNLOCK_T);
    run_window(1, 1'b0);
    check("eq_unlk_state", bus.state_o, 3);
    run_window(1, 1'b0);
    check("reunlk_state", bus.state_o, 2);

    // Most negative error saturates; enable dropped on the window-done cycle
    run_window(4, 1'b0);
    check("sat_sum", bus.win_sum_o, 131071 * 256);
    run_window(4, 1'b1);
    check("drop_state", bus.state_o, 0);
    check("drop_freeze", bus.freeze_o, 1);
    drive(1'b0, 1'b1, 500, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    drive(1'b1, 1'b0, 0, 1'b1);
    cyc();
    check("restart_clear", bus.lf_clear_o, 1);

    // Random traffic with occasional enable drops, then reset mid-run
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 262143)) - 131072, 1'($urandom_range(0, 1)));
      cyc();
    end
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 77, 1'b1);
    cyc();
    check("midrst_state", bus.state_o, 0);
    check("midrst_sum", bus.win_sum_o, 0);
    reset_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
